// File: rtl/idot_pkg.sv
// Shared constants for the sequential inertia-times-vector bank: sparse entry
// indices, per-row lane table and FSM state encoding.
package idot_pkg;

  localparam int unsigned NUM_ENTRIES = 24;
  localparam int unsigned NUM_LANES   = 5;
  localparam int unsigned NUM_ROWS    = 6;
  localparam int unsigned IDX_BITS    = 5;
  localparam int unsigned COL_BITS    = 3;
  localparam int unsigned ROW_BITS    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Vector component / column numbering
  localparam logic [COL_BITS-1:0] COL_AX = 3'd0;
  localparam logic [COL_BITS-1:0] COL_AY = 3'd1;
  localparam logic [COL_BITS-1:0] COL_AZ = 3'd2;
  localparam logic [COL_BITS-1:0] COL_LX = 3'd3;
  localparam logic [COL_BITS-1:0] COL_LY = 3'd4;
  localparam logic [COL_BITS-1:0] COL_LZ = 3'd5;

  // Sparse entry indices, named E_<row>_<col>
  localparam logic [IDX_BITS-1:0] E_AX_AX = 5'd0;
  localparam logic [IDX_BITS-1:0] E_AX_AY = 5'd1;
  localparam logic [IDX_BITS-1:0] E_AX_AZ = 5'd2;
  localparam logic [IDX_BITS-1:0] E_AX_LY = 5'd3;
  localparam logic [IDX_BITS-1:0] E_AX_LZ = 5'd4;
  localparam logic [IDX_BITS-1:0] E_AY_AX = 5'd5;
  localparam logic [IDX_BITS-1:0] E_AY_AY = 5'd6;
  localparam logic [IDX_BITS-1:0] E_AY_AZ = 5'd7;
  localparam logic [IDX_BITS-1:0] E_AY_LX = 5'd8;
  localparam logic [IDX_BITS-1:0] E_AY_LZ = 5'd9;
  localparam logic [IDX_BITS-1:0] E_AZ_AX = 5'd10;
  localparam logic [IDX_BITS-1:0] E_AZ_AY = 5'd11;
  localparam logic [IDX_BITS-1:0] E_AZ_AZ = 5'd12;
  localparam logic [IDX_BITS-1:0] E_AZ_LX = 5'd13;
  localparam logic [IDX_BITS-1:0] E_AZ_LY = 5'd14;
  localparam logic [IDX_BITS-1:0] E_LX_AY = 5'd15;
  localparam logic [IDX_BITS-1:0] E_LX_AZ = 5'd16;
  localparam logic [IDX_BITS-1:0] E_LX_LX = 5'd17;
  localparam logic [IDX_BITS-1:0] E_LY_AX = 5'd18;
  localparam logic [IDX_BITS-1:0] E_LY_AZ = 5'd19;
  localparam logic [IDX_BITS-1:0] E_LY_LY = 5'd20;
  localparam logic [IDX_BITS-1:0] E_LZ_AX = 5'd21;
  localparam logic [IDX_BITS-1:0] E_LZ_AY = 5'd22;
  localparam logic [IDX_BITS-1:0] E_LZ_LZ = 5'd23;

  // One multiplier lane: which bank entry and which vector column it uses
  typedef struct packed {
    logic                used;
    logic [IDX_BITS-1:0] idx;
    logic [COL_BITS-1:0] col;
  } lane_t;

  localparam lane_t LANE_UNUSED = '0;

  // Row-major lane table, NUM_LANES entries per row
  localparam lane_t LANE_TBL [NUM_ROWS*NUM_LANES] = '{
    {1'b1, E_AX_AX, COL_AX}, {1'b1, E_AX_AY, COL_AY}, {1'b1, E_AX_AZ, COL_AZ},
    {1'b1, E_AX_LY, COL_LY}, {1'b1, E_AX_LZ, COL_LZ},
    {1'b1, E_AY_AX, COL_AX}, {1'b1, E_AY_AY, COL_AY}, {1'b1, E_AY_AZ, COL_AZ},
    {1'b1, E_AY_LX, COL_LX}, {1'b1, E_AY_LZ, COL_LZ},
    {1'b1, E_AZ_AX, COL_AX}, {1'b1, E_AZ_AY, COL_AY}, {1'b1, E_AZ_AZ, COL_AZ},
    {1'b1, E_AZ_LX, COL_LX}, {1'b1, E_AZ_LY, COL_LY},
    {1'b1, E_LX_AY, COL_AY}, {1'b1, E_LX_AZ, COL_AZ}, {1'b1, E_LX_LX, COL_LX},
    LANE_UNUSED, LANE_UNUSED,
    {1'b1, E_LY_AX, COL_AX}, {1'b1, E_LY_AZ, COL_AZ}, {1'b1, E_LY_LY, COL_LY},
    LANE_UNUSED, LANE_UNUSED,
    {1'b1, E_LZ_AX, COL_AX}, {1'b1, E_LZ_AY, COL_AY}, {1'b1, E_LZ_LZ, COL_LZ},
    LANE_UNUSED, LANE_UNUSED
  };

  // Lane descriptor for a row (0..5) and lane (0..4)
  function automatic lane_t lane_lookup(input logic [ROW_BITS-1:0] row,
                                        input logic [2:0]          lane);
    return LANE_TBL[5'(row) * 5'(NUM_LANES) + 5'(lane)];
  endfunction

endpackage

// File: rtl/idot_row_mac.sv
// Combinational 5-lane fixed-point multiply with a 5-input wrapping adder tree.
module idot_row_mac
  import idot_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DECIMAL_BITS = 16
) (
  input  logic signed [WIDTH-1:0] coef [NUM_LANES],
  input  logic signed [WIDTH-1:0] opnd [NUM_LANES],
  output logic signed [WIDTH-1:0] sum_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic signed [PW-1:0]    prod [NUM_LANES];
  logic signed [WIDTH-1:0] term [NUM_LANES];

  // Full-width products, floor-scaled back to WIDTH, then summed modulo 2^WIDTH
  always_comb begin
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      prod[l] = PW'(coef[l]) * PW'(opnd[l]);
      term[l] = WIDTH'(prod[l] >>> DECIMAL_BITS);
    end
    sum_c = (term[0] + term[1]) + (term[2] + term[3]) + term[4];
  end

endmodule

// File: rtl/idot_seq_bank.sv
// Runtime-programmable sparse 6x6 inertia bank; one output row per cycle
// through a shared 5-lane MAC.
module idot_seq_bank
  import idot_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DECIMAL_BITS = 16,
  parameter int unsigned NUM_LINKS    = 7,
  parameter int unsigned LINK_BITS    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    imat_wr_en,
  input  logic [LINK_BITS-1:0]    imat_wr_link,
  input  logic [IDX_BITS-1:0]     imat_wr_idx,
  input  logic signed [WIDTH-1:0] imat_wr_data,
  output logic                    imat_wr_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LINK_BITS-1:0]    in_link,
  input  logic signed [WIDTH-1:0] vec_in_AX,
  input  logic signed [WIDTH-1:0] vec_in_AY,
  input  logic signed [WIDTH-1:0] vec_in_AZ,
  input  logic signed [WIDTH-1:0] vec_in_LX,
  input  logic signed [WIDTH-1:0] vec_in_LY,
  input  logic signed [WIDTH-1:0] vec_in_LZ,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LINK_BITS-1:0]    out_link,
  output logic                    out_err,
  output logic signed [WIDTH-1:0] ivec_out_AX,
  output logic signed [WIDTH-1:0] ivec_out_AY,
  output logic signed [WIDTH-1:0] ivec_out_AZ,
  output logic signed [WIDTH-1:0] ivec_out_LX,
  output logic signed [WIDTH-1:0] ivec_out_LY,
  output logic signed [WIDTH-1:0] ivec_out_LZ
);

  state_t                  state, state_next;
  logic [ROW_BITS-1:0]     row, row_next;
  logic                    accept_c;
  logic                    wr_bad_c;
  logic                    link_ok_c;
  logic [LINK_BITS-1:0]    link_q;
  logic signed [WIDTH-1:0] vec_q [NUM_ROWS];
  logic signed [WIDTH-1:0] res   [NUM_ROWS];
  logic signed [WIDTH-1:0] bank  [NUM_LINKS][NUM_ENTRIES];
  lane_t                   lane_c [NUM_LANES];
  logic signed [WIDTH-1:0] coef_c [NUM_LANES];
  logic signed [WIDTH-1:0] opnd_c [NUM_LANES];
  logic signed [WIDTH-1:0] row_sum_c;

  assign ivec_out_AX = res[0];
  assign ivec_out_AY = res[1];
  assign ivec_out_AZ = res[2];
  assign ivec_out_LX = res[3];
  assign ivec_out_LY = res[4];
  assign ivec_out_LZ = res[5];

  // State and row counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      row   <= '0;
    end else begin
      state <= state_next;
      row   <= row_next;
    end
  end

  // Next-state logic: accept in IDLE, walk six rows, hold in DONE until consumed
  always_comb begin
    state_next = state;
    row_next   = row;
    accept_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept_c   = 1'b1;
          state_next = ST_ROW;
          row_next   = '0;
        end
      end
      ST_ROW: begin
        if (row == ROW_BITS'(NUM_ROWS - 1)) begin
          state_next = ST_DONE;
          row_next   = '0;
        end else begin
          row_next = row + ROW_BITS'(1);
        end
      end
      ST_DONE: begin
        if (out_valid && out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Writes are dropped for bad index/link or for the slot currently in use
  assign wr_bad_c = (32'(imat_wr_idx) >= NUM_ENTRIES) ||
                    (32'(imat_wr_link) >= NUM_LINKS) ||
                    ((state != ST_IDLE) && (imat_wr_link == link_q));

  assign link_ok_c = 32'(link_q) < NUM_LINKS;

  // Row mux: live bank read for the current row; out-of-range link yields zero
  always_comb begin
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      lane_c[l] = lane_lookup(row, 3'(l));
      coef_c[l] = '0;
      if (lane_c[l].used && link_ok_c) coef_c[l] = bank[link_q][lane_c[l].idx];
      opnd_c[l] = vec_q[lane_c[l].col];
    end
  end

  idot_row_mac #(
    .WIDTH        (WIDTH),
    .DECIMAL_BITS (DECIMAL_BITS)
  ) u_row_mac (
    .coef  (coef_c),
    .opnd  (opnd_c),
    .sum_c (row_sum_c)
  );

  // Coefficient bank
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_LINKS); k++)
        for (int e = 0; e < int'(NUM_ENTRIES); e++)
          bank[k][e] <= '0;
    end else if (imat_wr_en && !wr_bad_c) begin
      bank[imat_wr_link][imat_wr_idx] <= imat_wr_data;
    end
  end

  // Input latch, per-row results and handshake/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      link_q      <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_err     <= 1'b0;
      out_link    <= '0;
      imat_wr_err <= 1'b0;
      for (int i = 0; i < int'(NUM_ROWS); i++) begin
        vec_q[i] <= '0;
        res[i]   <= '0;
      end
    end else begin
      in_ready    <= (state_next == ST_IDLE);
      imat_wr_err <= imat_wr_en && wr_bad_c;
      if (accept_c) begin
        link_q   <= in_link;
        vec_q[0] <= vec_in_AX;
        vec_q[1] <= vec_in_AY;
        vec_q[2] <= vec_in_AZ;
        vec_q[3] <= vec_in_LX;
        vec_q[4] <= vec_in_LY;
        vec_q[5] <= vec_in_LZ;
      end
      if (state == ST_ROW) res[row] <= row_sum_c;
      if ((state == ST_ROW) && (row == ROW_BITS'(NUM_ROWS - 1))) begin
        out_valid <= 1'b1;
        out_link  <= link_q;
        out_err   <= !link_ok_c;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_idot_seq_bank.sv
// Directed self-checking bench for idot_seq_bank.
module tb_idot_seq_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        imat_wr_en;
  logic [2:0]  imat_wr_link;
  logic [4:0]  imat_wr_idx;
  logic [31:0] imat_wr_data;
  logic        imat_wr_err;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_link;
  logic [31:0] vec_in_AX, vec_in_AY, vec_in_AZ, vec_in_LX, vec_in_LY, vec_in_LZ;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_link;
  logic        out_err;
  logic [31:0] ivec_out_AX, ivec_out_AY, ivec_out_AZ, ivec_out_LX, ivec_out_LY, ivec_out_LZ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idot_seq_bank dut (
    .clk          (clk),
    .reset        (reset),
    .imat_wr_en   (imat_wr_en),
    .imat_wr_link (imat_wr_link),
    .imat_wr_idx  (imat_wr_idx),
    .imat_wr_data (imat_wr_data),
    .imat_wr_err  (imat_wr_err),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_link      (in_link),
    .vec_in_AX    (vec_in_AX),
    .vec_in_AY    (vec_in_AY),
    .vec_in_AZ    (vec_in_AZ),
    .vec_in_LX    (vec_in_LX),
    .vec_in_LY    (vec_in_LY),
    .vec_in_LZ    (vec_in_LZ),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_link     (out_link),
    .out_err      (out_err),
    .ivec_out_AX  (ivec_out_AX),
    .ivec_out_AY  (ivec_out_AY),
    .ivec_out_AZ  (ivec_out_AZ),
    .ivec_out_LX  (ivec_out_LX),
    .ivec_out_LY  (ivec_out_LY),
    .ivec_out_LZ  (ivec_out_LZ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] link, input logic [4:0] idx,
                    input logic [31:0] data, input logic exp_err);
    imat_wr_en   = 1'b1;
    imat_wr_link = link;
    imat_wr_idx  = idx;
    imat_wr_data = data;
    tick();
    imat_wr_en = 1'b0;
    check("wr_err", 32'(imat_wr_err), 32'(exp_err));
  endtask

  task automatic set_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [31:0] e, input logic [31:0] f);
    vec_in_AX = a; vec_in_AY = b; vec_in_AZ = c;
    vec_in_LX = d; vec_in_LY = e; vec_in_LZ = f;
  endtask

  task automatic accept(input logic [2:0] link);
    in_link  = link;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("acc_busy", 32'(in_ready), 32'd0);
  endtask

  // elapsed = cycles already spent after the accept edge
  task automatic wait_out(input int elapsed);
    repeat (5 - elapsed) tick();
    check("lat_early", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic check_out(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [31:0] e4, input logic [31:0] e5,
                           input logic [2:0] elink, input logic eerr);
    check("out_AX", ivec_out_AX, e0);
    check("out_AY", ivec_out_AY, e1);
    check("out_AZ", ivec_out_AZ, e2);
    check("out_LX", ivec_out_LX, e3);
    check("out_LY", ivec_out_LY, e4);
    check("out_LZ", ivec_out_LZ, e5);
    check("out_link", 32'(out_link), 32'(elink));
    check("out_err", 32'(out_err), 32'(eerr));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rel_valid", 32'(out_valid), 32'd0);
    check("rel_ready", 32'(in_ready), 32'd1);
    check("rel_err", 32'(out_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imat_wr_en = 1'b0; imat_wr_link = '0; imat_wr_idx = '0; imat_wr_data = '0;
    in_valid = 1'b0; in_link = '0; out_ready = 1'b0;
    set_vec(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_wr_err", 32'(imat_wr_err), 32'd0);
    check("rst_out_link", 32'(out_link), 32'd0);
    check("rst_out_AX", ivec_out_AX, 32'h0);
    check("rst_out_LZ", ivec_out_LZ, 32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Identity on link 2
    wr(3'd2, 5'd0,  32'h0001_0000, 1'b0);
    wr(3'd2, 5'd6,  32'h0001_0000, 1'b0);
    wr(3'd2, 5'd12, 32'h0001_0000, 1'b0);
    wr(3'd2, 5'd17, 32'h0001_0000, 1'b0);
    wr(3'd2, 5'd20, 32'h0001_0000, 1'b0);
    wr(3'd2, 5'd23, 32'h0001_0000, 1'b0);
    set_vec(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000, 32'h6_0000);
    accept(3'd2);
    wait_out(0);
    check_out(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000, 32'h6_0000, 3'd2, 1'b0);
    release_out();

    // Every entry 0.5 on link 1, vector all 2.0
    for (int i = 0; i < 24; i++) wr(3'd1, 5'(i), 32'h0000_8000, 1'b0);
    set_vec(32'h2_0000, 32'h2_0000, 32'h2_0000, 32'h2_0000, 32'h2_0000, 32'h2_0000);
    accept(3'd1);
    wait_out(0);
    check_out(32'h5_0000, 32'h5_0000, 32'h5_0000, 32'h3_0000, 32'h3_0000, 32'h3_0000, 3'd1, 1'b0);
    release_out();

    // Floor rounding: -0.5 * 1 LSB
    wr(3'd3, 5'd0, 32'hFFFF_8000, 1'b0);
    set_vec(32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    accept(3'd3);
    wait_out(0);
    check_out(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd3, 1'b0);
    release_out();

    // Back-pressure: outputs held for 10 cycles
    set_vec(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000, 32'h6_0000);
    accept(3'd2);
    wait_out(0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_AX", ivec_out_AX, 32'h1_0000);
      check("hold_LZ", ivec_out_LZ, 32'h6_0000);
    end
    out_ready = 1'b1;
    tick();
    check("hs_ready", 32'(in_ready), 32'd1);
    check("hs_valid", 32'(out_valid), 32'd0);

    // Back-to-back accepts 8 cycles apart with out_ready held high
    accept(3'd2);
    repeat (5) tick();
    check("b2b_early", 32'(out_valid), 32'd0);
    tick();
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_first_AZ", ivec_out_AZ, 32'h3_0000);
    check("b2b_busy", 32'(in_ready), 32'd0);
    set_vec(32'hA_0000, 32'hB_0000, 32'hC_0000, 32'hD_0000, 32'hE_0000, 32'hF_0000);
    in_valid = 1'b1;
    tick();
    check("b2b_ready", 32'(in_ready), 32'd1);
    check("b2b_consumed", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("b2b_accept", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    wait_out(0);
    check_out(32'hA_0000, 32'hB_0000, 32'hC_0000, 32'hD_0000, 32'hE_0000, 32'hF_0000, 3'd2, 1'b0);
    release_out();

    // Writes while link 2 is in flight
    set_vec(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000, 32'h6_0000);
    accept(3'd2);
    wr(3'd2, 5'd23, 32'h0002_0000, 1'b1);
    wr(3'd4, 5'd0,  32'h0002_0000, 1'b0);
    wr(3'd4, 5'd24, 32'h0000_0001, 1'b1);
    tick();
    check("wr_err_clear", 32'(imat_wr_err), 32'd0);
    wait_out(4);
    check_out(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000, 32'h6_0000, 3'd2, 1'b0);
    release_out();
    wr(3'd7, 5'd0, 32'h0001_0000, 1'b1);

    // Write and accept of the same link in the same cycle
    set_vec(32'h3_0000, 32'h5_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    imat_wr_en = 1'b1; imat_wr_link = 3'd4; imat_wr_idx = 5'd6; imat_wr_data = 32'h1_0000;
    in_link = 3'd4; in_valid = 1'b1;
    tick();
    imat_wr_en = 1'b0; in_valid = 1'b0;
    check("same_wr_err", 32'(imat_wr_err), 32'd0);
    check("same_busy", 32'(in_ready), 32'd0);
    wait_out(0);
    check_out(32'h6_0000, 32'h5_0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd4, 1'b0);
    release_out();

    // Out-of-range link
    set_vec(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000, 32'h6_0000);
    accept(3'd7);
    wait_out(0);
    check_out(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd7, 1'b1);
    release_out();

    // Reset in the middle of a computation
    accept(3'd2);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_AX", ivec_out_AX, 32'h0);
    reset = 1'b0;
    tick();
    check("mid_rst_idle", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mid_rst_no_out", 32'(out_valid), 32'd0);
    end
    accept(3'd2);
    wait_out(0);
    check_out(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd2, 1'b0);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idot_seq_bank.md
Name: idot_seq_bank

Overview:
- Sequential, runtime-programmable successor to the constant-coefficient inertia-times-vector unit.
- Holds a register bank of sparse 6x6 spatial inertia matrices, one per link.
- Accepts a 6-vector plus a link index over a valid/ready handshake and computes one output row per cycle with 5 shared constant-free multipliers.
- Sits in the RNEA/dynamics pipeline wherever per-link inertia must be reloaded without resynthesis.

Parameters:
- WIDTH, 32, signed fixed-point word width.
- DECIMAL_BITS, 16, fractional bits.
- NUM_LINKS, 7, number of matrix slots in the bank.
- LINK_BITS, 3, width of link index; must satisfy 2^LINK_BITS >= NUM_LINKS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- imat_wr_en  in  1  bank write strobe.
- imat_wr_link  in  LINK_BITS  slot to write.
- imat_wr_idx  in  5  sparse entry index 0..23.
- imat_wr_data  in  WIDTH  entry value.
- imat_wr_err  out  1  one-cycle pulse when a write is dropped.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept.
- in_link  in  LINK_BITS  matrix slot to use.
- vec_in_AX, vec_in_AY, vec_in_AZ, vec_in_LX, vec_in_LY, vec_in_LZ  in  WIDTH each  input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_link  out  LINK_BITS  echoes the accepted in_link.
- out_err  out  1  in_link was out of range.
- ivec_out_AX, ivec_out_AY, ivec_out_AZ, ivec_out_LX, ivec_out_LY, ivec_out_LZ  out  WIDTH each  result vector.

Behaviour:
- Sparse entry map (row:col = idx):
  - AX: AX=0, AY=1, AZ=2, LY=3, LZ=4
  - AY: AX=5, AY=6, AZ=7, LX=8, LZ=9
  - AZ: AX=10, AY=11, AZ=12, LX=13, LY=14
  - LX: AY=15, AZ=16, LX=17
  - LY: AX=18, AZ=19, LY=20
  - LZ: AX=21, AY=22, LZ=23
  - All other entries are structurally zero.
- Reset: bank zeroed; state IDLE; in_ready=0 during the reset cycle and 1 from the first cycle after reset; out_valid=0, out_err=0, imat_wr_err=0, out_link=0, all ivec_out=0. Reset mid-computation aborts the operation; no output is produced.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch the vector and link, then go to ROW with row=0.
  - ROW: in_ready=0. Each cycle computes output row `row` (0..5 = AX,AY,AZ,LX,LY,LZ) into its result register and increments row. After row 5, go to DONE.
  - DONE: out_valid=1. Outputs and out_link are held stable while out_ready=0. On out_ready, go to IDLE.
- Latency: accept at edge t; out_valid high from cycle t+7. Minimum initiation interval is 8 cycles (accept resumes the cycle after the output handshake). No accept in DONE.
- Arithmetic:
  - Product = full 2*WIDTH signed product, arithmetic shift right by DECIMAL_BITS (rounds toward -inf), truncated to WIDTH.
  - Row sum is a 5-input tree (unused lanes multiply by 0). Additions wrap modulo 2^WIDTH; no saturation.
- Bank reads are live: row k reads the bank in its own cycle.
- Bank writes take effect at the next edge. A write is dropped (no bank change) and imat_wr_err pulses for 1 cycle if:
  - imat_wr_idx>23, or
  - imat_wr_link>=NUM_LINKS, or
  - state!=IDLE and imat_wr_link equals the latched link.
- A write in the same cycle as an accept of the same link is allowed and lands before row 0 reads.
- in_link>=NUM_LINKS is still accepted and follows the normal latency; result is all zeros with out_err=1. out_err clears with out_valid.
- Simultaneous reset with any strobe: reset wins.

Decomposition:
- Shared package idot_pkg holds:
  - the 24 entry-index constants,
  - the per-row lane table (entry idx and input column for lanes 0..4, with an "unused" marker),
  - the FSM state encoding (IDLE, ROW, DONE).
- Sub-module idot_row_mac: combinational 5-lane multiply plus 5-input adder tree, parameterised by WIDTH and DECIMAL_BITS. The parent owns the bank, FSM and row mux.

Test Plan:
- Load link 2 diagonal (idx 0,6,12,17,20,23 = 0x00010000); vec = 1..6 (0x10000..0x60000), accept at t -> out_valid at t+7, out = 1,2,3,4,5,6 (0x10000..0x60000), out_link=2.
- All 24 entries = 0x00008000, vec all 0x00020000 -> AX,AY,AZ = 0x00050000; LX,LY,LZ = 0x00030000.
- idx0 = 0xFFFF8000 (-0.5), vec_AX = 0x00000001, all other entries 0 -> ivec_out_AX = 0xFFFFFFFF (floor), all others 0.
- Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0 throughout; raise out_ready -> in_ready=1 on the next cycle; back-to-back accepts spaced exactly 8 cycles apart.
- During ROW on link 2:
  - write link 2 idx 0 -> imat_wr_err pulse, result uses the old value;
  - write link 4 idx 0 -> succeeds, no error;
  - write idx 24 -> error pulse.
- Assert reset at row 3 -> next cycle IDLE, out_valid=0, bank reads zero. Separately, in_link=7 with NUM_LINKS=7 -> zero vector, out_err=1 at t+7.
